// File: rtl/sap_apb_fabric_pkg.sv
// Shared configuration for the SAP APB fabric: bus widths, slave count,
// watchdog default and FSM state encodings.
package sap_apb_fabric_pkg;

  localparam int APB_DATA_WIDTH     = 32;
  localparam int PSELX_WIDTH        = 3;
  localparam int SAP_NUM_APB_SLAVES = 7;
  localparam int SAP_APB_TIMEOUT    = 64;
  localparam int SAP_ERR_CNT_WIDTH  = 8;

  localparam logic [1:0] ST_IDLE_ENC       = 2'd0;
  localparam logic [1:0] ST_ACCESS_ENC     = 2'd1;
  localparam logic [1:0] ST_ERR_ACCESS_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE       = ST_IDLE_ENC,
    ST_ACCESS     = ST_ACCESS_ENC,
    ST_ERR_ACCESS = ST_ERR_ACCESS_ENC
  } apb_state_e;

endpackage

// File: rtl/sap_apb_fabric_resp_mux.sv
// Combinational response selector: picks PREADY/PSLVERR/PRDATA of the slave
// addressed by the latched select index (index k -> slave k-1).
module sap_apb_resp_mux
  import sap_apb_fabric_pkg::*;
#(
  parameter int NUM_SLAVES = SAP_NUM_APB_SLAVES,
  parameter int SEL_W      = PSELX_WIDTH,
  parameter int DATA_W     = APB_DATA_WIDTH
) (
  input  logic [SEL_W-1:0]             sel,
  input  logic [NUM_SLAVES-1:0]        s_pready,
  input  logic [NUM_SLAVES-1:0]        s_pslverr,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_prdata,
  output logic                         pready,
  output logic                         pslverr,
  output logic [DATA_W-1:0]            prdata
);

  always_comb begin
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    for (int j = 0; j < NUM_SLAVES; j++) begin
      if (sel == SEL_W'(j + 1)) begin
        pready  = s_pready[j];
        pslverr = s_pslverr[j];
        prdata  = s_prdata[j*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/sap_apb_fabric.sv
// APB fabric between the SAP master wrapper and N security slaves: decode,
// lock/decode error responses, PREADY watchdog and saturating error counters.
module sap_apb_fabric
  import sap_apb_fabric_pkg::*;
#(
  parameter int NUM_SLAVES     = SAP_NUM_APB_SLAVES,
  parameter int SEL_W          = PSELX_WIDTH,
  parameter int DATA_W         = APB_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = SAP_APB_TIMEOUT,
  parameter int CNT_W          = SAP_ERR_CNT_WIDTH
) (
  input  logic                         PCLK,
  input  logic                         PRESET,
  input  logic [SEL_W-1:0]             m_psel_idx,
  input  logic                         m_penable,
  output logic                         m_pready,
  output logic                         m_pslverr,
  output logic [DATA_W-1:0]            m_prdata,
  input  logic [NUM_SLAVES-1:0]        slave_lock,
  output logic [NUM_SLAVES-1:0]        s_psel,
  output logic                         s_penable,
  input  logic [NUM_SLAVES-1:0]        s_pready,
  input  logic [NUM_SLAVES-1:0]        s_pslverr,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_prdata,
  output logic [CNT_W-1:0]             timeout_cnt,
  output logic [CNT_W-1:0]             decode_err_cnt,
  output logic [SEL_W-1:0]             last_err_idx
);

  apb_state_e        state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [15:0]       tcnt_q, tcnt_d;
  logic [CNT_W-1:0]  timeout_cnt_q, timeout_cnt_d;
  logic [CNT_W-1:0]  decode_err_cnt_q, decode_err_cnt_d;
  logic [SEL_W-1:0]  last_err_idx_q, last_err_idx_d;

  logic [NUM_SLAVES-1:0] setup_oh;
  logic [NUM_SLAVES-1:0] sel_oh;
  logic                  setup_valid;
  logic                  mux_pready;
  logic                  mux_pslverr;
  logic [DATA_W-1:0]     mux_prdata;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Out-of-range indices produce an all-zero one-hot, which makes them invalid.
  always_comb begin
    setup_oh = '0;
    sel_oh   = '0;
    for (int j = 0; j < NUM_SLAVES; j++) begin
      setup_oh[j] = (m_psel_idx == SEL_W'(j + 1));
      sel_oh[j]   = (sel_q == SEL_W'(j + 1));
    end
    setup_valid = |(setup_oh & ~slave_lock);
  end

  sap_apb_resp_mux #(
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_W      (SEL_W),
    .DATA_W     (DATA_W)
  ) u_resp_mux (
    .sel       (sel_q),
    .s_pready  (s_pready),
    .s_pslverr (s_pslverr),
    .s_prdata  (s_prdata),
    .pready    (mux_pready),
    .pslverr   (mux_pslverr),
    .prdata    (mux_prdata)
  );

  always_comb begin
    state_d          = state_q;
    sel_d            = sel_q;
    tcnt_d           = tcnt_q;
    timeout_cnt_d    = timeout_cnt_q;
    decode_err_cnt_d = decode_err_cnt_q;
    last_err_idx_d   = last_err_idx_q;
    m_pready         = 1'b1;
    m_pslverr        = 1'b0;
    m_prdata         = '0;
    s_psel           = '0;
    s_penable        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if ((m_psel_idx != '0) && !m_penable) begin
          sel_d  = m_psel_idx;
          tcnt_d = '0;
          if (setup_valid) begin
            s_psel  = setup_oh;
            state_d = ST_ACCESS;
          end else begin
            state_d = ST_ERR_ACCESS;
          end
        end
      end

      ST_ACCESS: begin
        s_psel    = sel_oh;
        s_penable = m_penable;
        m_pready  = mux_pready;
        m_pslverr = mux_pslverr;
        m_prdata  = mux_prdata;
        if (mux_pready) begin
          state_d = ST_IDLE;
        end else if (tcnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          // Watchdog forces an error completion; the slave keeps PSEL no longer.
          m_pready       = 1'b1;
          m_pslverr      = 1'b1;
          m_prdata       = '0;
          timeout_cnt_d  = sat_inc(timeout_cnt_q);
          last_err_idx_d = sel_q;
          state_d        = ST_IDLE;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end

      ST_ERR_ACCESS: begin
        if (m_penable) begin
          m_pslverr        = 1'b1;
          decode_err_cnt_d = sat_inc(decode_err_cnt_q);
          last_err_idx_d   = sel_q;
          state_d          = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // The SETUP decode is combinational, so gate it while reset is held.
    if (PRESET) begin
      s_psel    = '0;
      s_penable = 1'b0;
      m_pready  = 1'b1;
      m_pslverr = 1'b0;
      m_prdata  = '0;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q          <= ST_IDLE;
      sel_q            <= '0;
      tcnt_q           <= '0;
      timeout_cnt_q    <= '0;
      decode_err_cnt_q <= '0;
      last_err_idx_q   <= '0;
    end else begin
      state_q          <= state_d;
      sel_q            <= sel_d;
      tcnt_q           <= tcnt_d;
      timeout_cnt_q    <= timeout_cnt_d;
      decode_err_cnt_q <= decode_err_cnt_d;
      last_err_idx_q   <= last_err_idx_d;
    end
  end

  assign timeout_cnt    = timeout_cnt_q;
  assign decode_err_cnt = decode_err_cnt_q;
  assign last_err_idx   = last_err_idx_q;

endmodule

// File: tb/tb_sap_apb_fabric.sv
// Bench for sap_apb_fabric: directed scenarios plus randomized transfers
// scored against a transfer-level model of decode, wait states and watchdog.
module tb_sap_apb_fabric;

  localparam int NS  = 6;
  localparam int SW  = 3;
  localparam int DW  = 32;
  localparam int TO  = 8;
  localparam int CW  = 8;
  localparam int SAT = (1 << CW) - 1;

  logic             PCLK = 1'b0;
  logic             PRESET;
  logic [SW-1:0]    m_psel_idx;
  logic             m_penable;
  logic             m_pready;
  logic             m_pslverr;
  logic [DW-1:0]    m_prdata;
  logic [NS-1:0]    slave_lock;
  logic [NS-1:0]    s_psel;
  logic             s_penable;
  logic [NS-1:0]    s_pready;
  logic [NS-1:0]    s_pslverr;
  logic [NS*DW-1:0] s_prdata;
  logic [CW-1:0]    timeout_cnt;
  logic [CW-1:0]    decode_err_cnt;
  logic [SW-1:0]    last_err_idx;

  int n_cmp  = 0;
  int n_fail = 0;
  int mdl_to, mdl_dec, mdl_last;

  sap_apb_fabric #(
    .NUM_SLAVES(NS), .SEL_W(SW), .DATA_W(DW), .TIMEOUT_CYCLES(TO), .CNT_W(CW)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .m_psel_idx(m_psel_idx), .m_penable(m_penable),
    .m_pready(m_pready), .m_pslverr(m_pslverr), .m_prdata(m_prdata),
    .slave_lock(slave_lock), .s_psel(s_psel), .s_penable(s_penable),
    .s_pready(s_pready), .s_pslverr(s_pslverr), .s_prdata(s_prdata),
    .timeout_cnt(timeout_cnt), .decode_err_cnt(decode_err_cnt), .last_err_idx(last_err_idx)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "bench timeout");
  end

  // Transfer-level model: what the master must observe for one transfer.
  task automatic predict(input int idx, input logic [NS-1:0] lock, input int wait_n,
                         input logic [DW-1:0] rdata, input logic serr,
                         output int e_acc, output logic e_err, output logic [DW-1:0] e_data,
                         output int e_hits);
    bit ok;
    ok = 1'b0;
    if (idx >= 1 && idx <= NS) ok = !lock[idx-1];
    if (!ok) begin
      e_acc = 1; e_err = 1'b1; e_data = '0; e_hits = 0;
      mdl_dec = (mdl_dec < SAT) ? mdl_dec + 1 : SAT;
      mdl_last = idx;
    end else if (wait_n >= TO) begin
      e_acc = TO; e_err = 1'b1; e_data = '0; e_hits = TO + 1;
      mdl_to = (mdl_to < SAT) ? mdl_to + 1 : SAT;
      mdl_last = idx;
    end else begin
      e_acc = wait_n + 1; e_err = serr; e_data = rdata; e_hits = wait_n + 2;
    end
  endtask

  // Drives one SETUP+ACCESS transfer; target slave holds PREADY low for wait_n cycles.
  task automatic xfer(input int idx, input logic [NS-1:0] lock, input int wait_n,
                      input logic [DW-1:0] rdata, input logic serr,
                      output int acc, output logic err, output logic [DW-1:0] data,
                      output int hits, output int bad, output int pen_bad);
    int tgt;
    logic [NS-1:0] exp_oh;
    tgt = idx - 1;
    exp_oh = '0;
    if (idx >= 1 && idx <= NS) begin
      if (!lock[idx-1]) exp_oh[idx-1] = 1'b1;
    end
    acc = 0; err = 1'b0; data = '0; hits = 0; bad = 0; pen_bad = 0;
    @(posedge PCLK); #1;
    m_psel_idx = SW'(idx);
    m_penable  = 1'b0;
    slave_lock = lock;
    for (int j = 0; j < NS; j++) begin
      s_prdata[j*DW +: DW] = $urandom;
      s_pready[j]  = 1'($urandom);
      s_pslverr[j] = 1'($urandom);
    end
    if (tgt >= 0 && tgt < NS) begin
      s_prdata[tgt*DW +: DW] = rdata;
      s_pslverr[tgt] = serr;
      s_pready[tgt]  = (wait_n == 0);
    end
    @(negedge PCLK);
    if (exp_oh != '0 && s_psel === exp_oh) hits++;
    else if (s_psel !== '0) bad++;
    @(posedge PCLK); #1;
    m_penable  = 1'b1;
    slave_lock = NS'($urandom);
    for (int c = 1; c <= 40; c++) begin
      if (tgt >= 0 && tgt < NS) s_pready[tgt] = (c > wait_n);
      if (c == 2) m_psel_idx = SW'($urandom);
      @(negedge PCLK);
      if (exp_oh != '0 && s_psel === exp_oh) hits++;
      else if (s_psel !== '0) bad++;
      if (exp_oh != '0 && s_penable !== 1'b1) pen_bad++;
      if (m_pready === 1'b1) begin
        acc = c; err = m_pslverr; data = m_prdata;
        break;
      end
      @(posedge PCLK); #1;
    end
  endtask

  task automatic go_idle(output logic [NS-1:0] psel_after);
    @(posedge PCLK); #1;
    m_psel_idx = '0;
    m_penable  = 1'b0;
    @(negedge PCLK);
    psel_after = s_psel;
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    m_psel_idx = '0; m_penable = 1'b0; slave_lock = '0;
    s_pready = '1; s_pslverr = '0; s_prdata = '0;
    mdl_to = 0; mdl_dec = 0; mdl_last = 0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);
    n_cmp++; if (m_pready !== 1'b1) begin n_fail++; $display("FAIL reset_pready: got %b want 1", m_pready); end
    n_cmp++; if (m_pslverr !== 1'b0) begin n_fail++; $display("FAIL reset_pslverr: got %b want 0", m_pslverr); end
    n_cmp++; if (m_prdata !== '0) begin n_fail++; $display("FAIL reset_prdata: got %h want 0", m_prdata); end
    n_cmp++; if (s_psel !== '0 || s_penable !== 1'b0) begin n_fail++; $display("FAIL reset_psel: got %b/%b want 0/0", s_psel, s_penable); end
    n_cmp++; if (timeout_cnt !== '0 || decode_err_cnt !== '0 || last_err_idx !== '0) begin
      n_fail++; $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", timeout_cnt, decode_err_cnt, last_err_idx);
    end
  endtask

  task automatic test_read_basic();
    int acc, hits, bad, pb, e_acc, e_hits;
    logic err, e_err;
    logic [DW-1:0] data, e_data;
    logic [NS-1:0] after;
    predict(4, '0, 0, 32'hA5A5_0003, 1'b0, e_acc, e_err, e_data, e_hits);
    xfer(4, '0, 0, 32'hA5A5_0003, 1'b0, acc, err, data, hits, bad, pb);
    go_idle(after);
    n_cmp++; if (data !== 32'hA5A5_0003 || err !== 1'b0) begin n_fail++; $display("FAIL basic_data: got %h/%b want a5a50003/0", data, err); end
    n_cmp++; if (hits != 2 || bad != 0 || after !== '0) begin n_fail++; $display("FAIL basic_psel: got hits %0d bad %0d after %b want 2 0 0", hits, bad, after); end
    n_cmp++; if (acc != e_acc || pb != 0) begin n_fail++; $display("FAIL basic_latency: got %0d pen_bad %0d want %0d 0", acc, pb, e_acc); end
    n_cmp++; if (timeout_cnt !== 8'd0 || decode_err_cnt !== 8'd0) begin n_fail++; $display("FAIL basic_counters: got %0d/%0d want 0/0", timeout_cnt, decode_err_cnt); end
  endtask

  task automatic test_wait_states();
    int acc, hits, bad, pb;
    logic err;
    logic [DW-1:0] data;
    logic [NS-1:0] after;
    xfer(2, '0, 5, 32'h1234_5678, 1'b0, acc, err, data, hits, bad, pb);
    go_idle(after);
    n_cmp++; if (acc != 6 || err !== 1'b0 || data !== 32'h1234_5678) begin
      n_fail++; $display("FAIL wait5: got cycle %0d err %b data %h want 6 0 12345678", acc, err, data);
    end
    n_cmp++; if (timeout_cnt !== 8'd0 || hits != 7) begin n_fail++; $display("FAIL wait5_cnt: got to %0d hits %0d want 0 7", timeout_cnt, hits); end
  endtask

  task automatic test_timeout();
    int acc, hits, bad, pb;
    logic err;
    logic [DW-1:0] data;
    logic [NS-1:0] after;
    xfer(1, '0, 100, 32'hDEAD_BEEF, 1'b0, acc, err, data, hits, bad, pb);
    go_idle(after);
    mdl_to = mdl_to + 1; mdl_last = 1;
    n_cmp++; if (acc != TO || err !== 1'b1 || data !== '0) begin
      n_fail++; $display("FAIL timeout_resp: got cycle %0d err %b data %h want %0d 1 0", acc, err, data, TO);
    end
    n_cmp++; if (timeout_cnt !== CW'(mdl_to) || last_err_idx !== 3'd1 || after !== '0) begin
      n_fail++; $display("FAIL timeout_cnt: got %0d last %0d psel %b want %0d 1 0", timeout_cnt, last_err_idx, after, mdl_to);
    end
    xfer(1, '0, TO - 1, 32'hCAFE_0001, 1'b0, acc, err, data, hits, bad, pb);
    go_idle(after);
    n_cmp++; if (acc != TO || err !== 1'b0 || data !== 32'hCAFE_0001 || timeout_cnt !== CW'(mdl_to)) begin
      n_fail++; $display("FAIL timeout_race: got cycle %0d err %b data %h to %0d want %0d 0 cafe0001 %0d", acc, err, data, timeout_cnt, TO, mdl_to);
    end
  endtask

  task automatic test_decode_err();
    int acc, hits, bad, pb;
    logic err;
    logic [DW-1:0] data;
    logic [NS-1:0] after;
    xfer(3, 6'b000100, 0, 32'h1111_1111, 1'b0, acc, err, data, hits, bad, pb);
    go_idle(after);
    n_cmp++; if (acc != 1 || err !== 1'b1 || data !== '0 || hits != 0 || bad != 0) begin
      n_fail++; $display("FAIL lock_err: got cycle %0d err %b data %h psel bad %0d want 1 1 0 0", acc, err, data, bad);
    end
    xfer(7, '0, 0, 32'h2222_2222, 1'b0, acc, err, data, hits, bad, pb);
    go_idle(after);
    mdl_dec = mdl_dec + 2; mdl_last = 7;
    n_cmp++; if (acc != 1 || err !== 1'b1 || data !== '0 || bad != 0) begin
      n_fail++; $display("FAIL range_err: got cycle %0d err %b data %h psel bad %0d want 1 1 0 0", acc, err, data, bad);
    end
    n_cmp++; if (decode_err_cnt !== CW'(mdl_dec) || last_err_idx !== 3'd7) begin
      n_fail++; $display("FAIL decode_cnt: got %0d last %0d want %0d 7", decode_err_cnt, last_err_idx, mdl_dec);
    end
  endtask

  task automatic test_random(input int n, input bit b2b);
    int acc, hits, bad, pb, e_acc, e_hits, idx, wn;
    logic err, e_err, serr;
    logic [DW-1:0] data, e_data, rd;
    logic [NS-1:0] lock, after;
    for (int t = 0; t < n; t++) begin
      idx  = $urandom_range(7, 1);
      lock = ($urandom_range(3, 0) == 0) ? NS'($urandom) : '0;
      wn   = $urandom_range(TO + 3, 0);
      rd   = $urandom;
      serr = 1'($urandom);
      predict(idx, lock, wn, rd, serr, e_acc, e_err, e_data, e_hits);
      xfer(idx, lock, wn, rd, serr, acc, err, data, hits, bad, pb);
      after = '0;
      if (!b2b) go_idle(after);
      n_cmp++;
      if (acc != e_acc || err !== e_err || data !== e_data || hits != e_hits || bad != 0 || pb != 0 || after !== '0) begin
        n_fail++;
        $display("FAIL rand_xfer idx=%0d wait=%0d lock=%b: got cyc %0d err %b data %h hits %0d bad %0d pen %0d after %b want cyc %0d err %b data %h hits %0d",
                 idx, wn, lock, acc, err, data, hits, bad, pb, after, e_acc, e_err, e_data, e_hits);
      end
    end
    if (b2b) go_idle(after);
    n_cmp++;
    if (timeout_cnt !== CW'(mdl_to) || decode_err_cnt !== CW'(mdl_dec) || last_err_idx !== SW'(mdl_last)) begin
      n_fail++;
      $display("FAIL rand_counters: got %0d/%0d/%0d want %0d/%0d/%0d", timeout_cnt, decode_err_cnt, last_err_idx, mdl_to, mdl_dec, mdl_last);
    end
  endtask

  task automatic test_saturation();
    int acc, hits, bad, pb, e_acc, e_hits, idx;
    logic err, e_err;
    logic [DW-1:0] data, e_data;
    logic [NS-1:0] after;
    for (int t = 0; t < 300; t++) begin
      idx = $urandom_range(NS, 1);
      predict(idx, '1, 0, '0, 1'b0, e_acc, e_err, e_data, e_hits);
      xfer(idx, '1, 0, '0, 1'b0, acc, err, data, hits, bad, pb);
    end
    go_idle(after);
    n_cmp++; if (decode_err_cnt !== 8'd255 || mdl_dec != SAT) begin
      n_fail++; $display("FAIL dec_saturate: got %0d want 255", decode_err_cnt);
    end
    n_cmp++; if (last_err_idx !== SW'(mdl_last) || timeout_cnt !== CW'(mdl_to)) begin
      n_fail++; $display("FAIL sat_side: got last %0d to %0d want %0d %0d", last_err_idx, timeout_cnt, mdl_last, mdl_to);
    end
  endtask

  task automatic test_reset_mid();
    int acc, hits, bad, pb;
    logic err;
    logic [DW-1:0] data;
    logic [NS-1:0] after;
    @(posedge PCLK); #1;
    m_psel_idx = 3'd2; m_penable = 1'b0; slave_lock = '0; s_pready = '0;
    @(posedge PCLK); #1;
    m_penable = 1'b1;
    repeat (2) @(posedge PCLK);
    #1;
    n_cmp++; if (s_psel !== 6'b000010) begin n_fail++; $display("FAIL mid_pre: got psel %b want 000010", s_psel); end
    PRESET = 1'b1;
    #1;
    mdl_to = 0; mdl_dec = 0; mdl_last = 0;
    n_cmp++; if (s_psel !== '0 || m_pready !== 1'b1 || m_pslverr !== 1'b0 || s_penable !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_out: got psel %b pready %b pslverr %b pen %b want 0 1 0 0", s_psel, m_pready, m_pslverr, s_penable);
    end
    n_cmp++; if (decode_err_cnt !== '0 || timeout_cnt !== '0 || last_err_idx !== '0) begin
      n_fail++; $display("FAIL mid_reset_cnt: got %0d/%0d/%0d want 0/0/0", timeout_cnt, decode_err_cnt, last_err_idx);
    end
    @(negedge PCLK);
    m_psel_idx = '0; m_penable = 1'b0;
    PRESET = 1'b0;
    xfer(5, '0, 2, 32'h5555_0004, 1'b0, acc, err, data, hits, bad, pb);
    go_idle(after);
    n_cmp++; if (acc != 3 || err !== 1'b0 || data !== 32'h5555_0004 || hits != 4 || bad != 0) begin
      n_fail++; $display("FAIL mid_next_xfer: got cyc %0d err %b data %h hits %0d bad %0d want 3 0 55550004 4 0", acc, err, data, hits, bad);
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_wait_states();
    test_timeout();
    test_decode_err();
    test_random(60, 1'b0);
    test_random(20, 1'b1);
    test_saturation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
